// File: rtl/bus_fabric_n_if.sv
// CPU-side and slave-side signals of the parametrised data-bus fabric.
// master = CPU data port, slave = slave blocks, fabric = the decoder itself.
interface bus_fabric_n_if #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int SEL_BITS = 2
);
   localparam int N    = 2 ** SEL_BITS;
   localparam int SA_W = ADDR_W - SEL_BITS;

   logic [ADDR_W-1:0]   m_addr;
   logic [DATA_W-1:0]   m_wdata;
   logic                m_write;
   logic                m_read;
   logic [DATA_W-1:0]   m_rdata;
   logic                m_ready;
   logic                m_err;
   logic [N-1:0]        s_cs;
   logic [SA_W-1:0]     s_addr;
   logic [DATA_W-1:0]   s_wdata;
   logic                s_write;
   logic                s_read;
   logic [N*DATA_W-1:0] s_rdata;
   logic [N-1:0]        s_ready;

   modport master (
      output m_addr, m_wdata, m_write, m_read,
      input  m_rdata, m_ready, m_err
   );

   modport slave (
      input  s_cs, s_addr, s_wdata, s_write, s_read,
      output s_rdata, s_ready
   );

   modport fabric (
      input  m_addr, m_wdata, m_write, m_read, s_rdata, s_ready,
      output m_rdata, m_ready, m_err, s_cs, s_addr, s_wdata, s_write, s_read
   );
endinterface

// File: rtl/bus_fabric_n.sv
// One-master to 2**SEL_BITS-slave data-bus fabric: address-decoded chip select,
// per-slave ready handshake, unmapped/timeout error response and saturating error count.
module bus_fabric_n #(
   parameter int                     ADDR_W     = 16,
   parameter int                     DATA_W     = 16,
   parameter int                     SEL_BITS   = 2,
   parameter logic [2**SEL_BITS-1:0] SLAVE_MASK = 4'b0011,
   parameter int unsigned            TIMEOUT    = 15,
   parameter logic [DATA_W-1:0]      ERR_DATA   = 16'hFFFF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bus_fabric_n_if.fabric        bus,
   output logic [7:0]            err_count
);
   localparam int N     = 2 ** SEL_BITS;
   localparam int SA_W  = ADDR_W - SEL_BITS;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

   state_t              state;
   logic [SEL_BITS-1:0] sel;
   logic [SEL_BITS-1:0] req_sel;
   logic [N-1:0]        req_cs;
   logic                is_write;
   logic [CNT_W-1:0]    cnt;
   logic                timed_out;
   logic [7:0]          err_next;

   always_comb begin
      req_sel          = bus.m_addr[ADDR_W-1 -: SEL_BITS];
      req_cs           = '0;
      req_cs[req_sel]  = 1'b1;
      timed_out        = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));
      err_next         = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sel         <= '0;
         is_write    <= 1'b0;
         cnt         <= '0;
         err_count   <= '0;
         bus.m_rdata <= '0;
         bus.m_ready <= 1'b0;
         bus.m_err   <= 1'b0;
         bus.s_cs    <= '0;
         bus.s_addr  <= '0;
         bus.s_wdata <= '0;
         bus.s_write <= 1'b0;
         bus.s_read  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.m_read || bus.m_write) begin
                  sel         <= req_sel;
                  is_write    <= bus.m_write;
                  cnt         <= '0;
                  bus.s_addr  <= bus.m_addr[SA_W-1:0];
                  bus.s_wdata <= bus.m_wdata;
                  if (SLAVE_MASK[req_sel]) begin
                     state       <= ACCESS;
                     bus.s_cs    <= req_cs;
                     // a simultaneous read and write request is treated as a write
                     bus.s_write <= bus.m_write;
                     bus.s_read  <= !bus.m_write;
                  end else begin
                     state       <= ERR;
                     bus.m_ready <= 1'b1;
                     bus.m_err   <= 1'b1;
                     bus.m_rdata <= ERR_DATA;
                     err_count   <= err_next;
                  end
               end
            end
            ACCESS: begin
               // ready is tested before the timeout so a last-cycle ready still completes
               if (bus.s_ready[sel]) begin
                  state       <= RESP;
                  bus.m_ready <= 1'b1;
                  bus.m_err   <= 1'b0;
                  if (!is_write) bus.m_rdata <= bus.s_rdata[sel*DATA_W +: DATA_W];
                  bus.s_cs    <= '0;
                  bus.s_write <= 1'b0;
                  bus.s_read  <= 1'b0;
               end else if (timed_out) begin
                  state       <= ERR;
                  bus.m_ready <= 1'b1;
                  bus.m_err   <= 1'b1;
                  bus.m_rdata <= ERR_DATA;
                  err_count   <= err_next;
                  bus.s_cs    <= '0;
                  bus.s_write <= 1'b0;
                  bus.s_read  <= 1'b0;
               end else if (TIMEOUT != 0) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP, ERR: begin
               state       <= IDLE;
               bus.m_ready <= 1'b0;
               bus.m_err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_fabric_n.sv
// Randomised bench for bus_fabric_n: a transaction-level model predicts per-cycle bus outputs,
// a compare process checks them every cycle, and directed cases pin known latencies and values.
module tb_bus_fabric_n;
   localparam int          TO   = 15;
   localparam logic [3:0]  MASK = 4'b0011;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] err_count;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   logic [3:0]  exp_cs;
   logic        exp_sw, exp_sr, exp_ready, exp_err;
   logic [15:0] exp_rdata, exp_swdata;
   logic [13:0] exp_saddr;
   logic [7:0]  exp_errcnt;

   bus_fabric_n_if #(.ADDR_W(16), .DATA_W(16), .SEL_BITS(2)) bus ();

   bus_fabric_n #(
      .ADDR_W(16), .DATA_W(16), .SEL_BITS(2),
      .SLAVE_MASK(MASK), .TIMEOUT(TO), .ERR_DATA(16'hFFFF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (chk_en) begin
            chk("s_cs",      32'(bus.s_cs),    32'(exp_cs));
            chk("s_write",   32'(bus.s_write), 32'(exp_sw));
            chk("s_read",    32'(bus.s_read),  32'(exp_sr));
            chk("m_ready",   32'(bus.m_ready), 32'(exp_ready));
            chk("m_err",     32'(bus.m_err),   32'(exp_err));
            chk("m_rdata",   32'(bus.m_rdata), 32'(exp_rdata));
            chk("s_addr",    32'(bus.s_addr),  32'(exp_saddr));
            chk("s_wdata",   32'(bus.s_wdata), 32'(exp_swdata));
            chk("err_count", 32'(err_count),   32'(exp_errcnt));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      exp_cs = '0; exp_sw = 0; exp_sr = 0; exp_ready = 0; exp_err = 0;
      exp_rdata = '0; exp_swdata = '0; exp_saddr = '0; exp_errcnt = '0;
   endtask

   task automatic noise();
      bus.s_rdata = {$urandom, $urandom};
      bus.s_ready = 4'($urandom);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      noise();
      exp_cs = '0; exp_sw = 0; exp_sr = 0; exp_ready = 0; exp_err = 0;
   endtask

   // delay = ACCESS cycle in which the selected slave raises s_ready; 0 = never
   task automatic do_txn(input logic [15:0] addr, input bit w, input bit both,
                         input logic [15:0] wd, input int unsigned delay,
                         input logic [15:0] sd, output int unsigned lat,
                         output logic [3:0] cs1, output int unsigned wcnt,
                         output int unsigned rcnt);
      int unsigned sel, rc;
      bit mapped, err;
      sel    = int'(addr[15:14]);
      mapped = MASK[sel];
      if (!mapped) begin
         rc = 1; err = 1;
      end else if (delay != 0 && delay <= TO + 1) begin
         rc = delay + 1; err = 0;
      end else begin
         rc = TO + 2; err = 1;
      end
      lat = 0; cs1 = '0; wcnt = 0; rcnt = 0;
      repeat ($urandom_range(0, 2)) idle_cycle();
      idle_cycle();
      bus.m_addr  = addr;
      bus.m_wdata = wd;
      bus.m_write = w;
      bus.m_read  = !w || both;
      for (int unsigned k = 1; k <= rc; k++) begin
         @(negedge clk);
         noise();
         bus.s_rdata[sel*16 +: 16] = sd;
         bus.s_ready[sel] = mapped && (k == delay);
         if (k == 1) begin
            exp_saddr  = addr[13:0];
            exp_swdata = wd;
         end
         if (k < rc) begin
            exp_cs = '0; exp_cs[sel] = 1'b1;
            exp_sw = w; exp_sr = !w; exp_ready = 0; exp_err = 0;
            bus.m_addr  = 16'($urandom);
            bus.m_wdata = 16'($urandom);
         end else begin
            exp_cs = '0; exp_sw = 0; exp_sr = 0; exp_ready = 1; exp_err = err;
            if (err) exp_rdata = 16'hFFFF;
            else if (!w) exp_rdata = sd;
            if (err && exp_errcnt != 8'd255) exp_errcnt++;
            bus.m_read  = 0;
            bus.m_write = 0;
         end
         #1;
         if (bus.m_ready && lat == 0) lat = k;
         if (k == 1) cs1 = bus.s_cs;
         wcnt += int'(bus.s_write);
         rcnt += int'(bus.s_read);
      end
   endtask

   initial begin
      int unsigned lat, wc, rc, r, dly;
      logic [3:0]  cs1;
      logic [15:0] a;
      bit          w;

      rst_n = 1'b0;
      bus.m_addr = '0; bus.m_wdata = '0; bus.m_write = 0; bus.m_read = 0;
      bus.s_rdata = '0; bus.s_ready = '0;
      model_reset();
      #2;
      chk("rst_m_ready",   32'(bus.m_ready), 0);
      chk("rst_m_rdata",   32'(bus.m_rdata), 0);
      chk("rst_s_cs",      32'(bus.s_cs),    0);
      chk("rst_err_count", 32'(err_count),   0);
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      do_txn(16'h4005, 0, 0, 16'h1234, 1, 16'hBEEF, lat, cs1, wc, rc);
      chk("beef_lat",   lat, 2);
      chk("beef_cs",    32'(cs1), 32'h2);
      chk("beef_rdata", 32'(bus.m_rdata), 32'hBEEF);
      chk("beef_err",   32'(bus.m_err), 0);
      chk("beef_saddr", 32'(bus.s_addr), 32'h0005);

      do_txn(16'h0010, 1, 0, 16'h00A5, 3, 16'h5555, lat, cs1, wc, rc);
      chk("wr_lat",    lat, 4);
      chk("wr_cycles", wc, 3);
      chk("wr_wdata",  32'(bus.s_wdata), 32'h00A5);

      do_txn(16'h8000, 0, 0, 16'h0000, 1, 16'h0000, lat, cs1, wc, rc);
      chk("unmap_lat",   lat, 1);
      chk("unmap_cs",    32'(cs1), 0);
      chk("unmap_err",   32'(bus.m_err), 1);
      chk("unmap_rdata", 32'(bus.m_rdata), 32'hFFFF);
      chk("unmap_cnt",   32'(err_count), 1);

      do_txn(16'h0000, 0, 0, 16'h0000, 0, 16'h0000, lat, cs1, wc, rc);
      chk("tmo_lat", lat, 17);
      chk("tmo_err", 32'(bus.m_err), 1);
      chk("tmo_cnt", 32'(err_count), 2);

      do_txn(16'h4000, 1, 1, 16'h0F0F, 2, 16'h0000, lat, cs1, wc, rc);
      chk("both_wr", wc, 2);
      chk("both_rd", rc, 0);

      do_txn(16'h7FFF, 0, 0, 16'h0000, 16, 16'hCAFE, lat, cs1, wc, rc);
      chk("edge_lat",   lat, 17);
      chk("edge_err",   32'(bus.m_err), 0);
      chk("edge_rdata", 32'(bus.m_rdata), 32'hCAFE);

      // reset while an access is in flight
      idle_cycle();
      chk_en = 1'b0;
      bus.m_addr = 16'h0001; bus.m_read = 1; bus.m_write = 0; bus.s_ready = '0;
      repeat (3) begin
         @(negedge clk);
         bus.s_ready = '0;
      end
      #1;
      chk("pre_rst_cs", 32'(bus.s_cs), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_cs",    32'(bus.s_cs),    0);
      chk("mid_rst_read",  32'(bus.s_read),  0);
      chk("mid_rst_ready", 32'(bus.m_ready), 0);
      chk("mid_rst_cnt",   32'(err_count),   0);
      bus.m_read = 0;
      model_reset();
      @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      repeat (2) idle_cycle();
      do_txn(16'h4005, 0, 0, 16'h0000, 2, 16'h1357, lat, cs1, wc, rc);
      chk("post_rst_lat", lat, 3);

      for (int i = 0; i < 150; i++) begin
         a   = 16'($urandom);
         w   = 1'($urandom);
         r   = $urandom_range(0, 19);
         dly = (r < 2) ? 0 : r - 1;
         do_txn(a, w, w & 1'($urandom), 16'($urandom), dly, 16'($urandom), lat, cs1, wc, rc);
      end

      for (int i = 0; i < 300; i++) begin
         a = {1'b0, 15'($urandom)};
         do_txn(a, 1'($urandom), 0, 16'($urandom), 0, 16'($urandom), lat, cs1, wc, rc);
      end
      chk("err_sat", 32'(err_count), 255);

      repeat (3) idle_cycle();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
